// File: rtl/spmv_rd_fetch_if.sv
// AXI4 read-channel and downstream 256-bit FIFO write-side signals of the SpMV
// read fetcher, bundled so the fetcher and its environment share one port.
interface spmv_rd_fetch_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 4
);
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic                  m_axi_rvalid;
  logic                  m_axi_rlast;
  logic                  m_axi_rready;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_full;
  logic                  fifo_needdata;
  logic                  fifo_noneeddata;
  logic [FIFO_DEPTH:0]   fifo_fill_level;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready, fifo_wr_en, fifo_data_in,
    input  m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast,
    input  fifo_full, fifo_needdata, fifo_noneeddata, fifo_fill_level
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready, fifo_wr_en, fifo_data_in,
    output m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast,
    output fifo_full, fifo_needdata, fifo_noneeddata, fifo_fill_level
  );
endinterface

// File: rtl/spmv_rd_fetch.sv
// Streams a contiguous region of 256-bit words over AXI4 read bursts into the
// downstream FIFO, throttled by FIFO hysteresis and a beat-credit check.
module spmv_rd_fetch #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 256,
  parameter int BURST_LEN       = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_beats,
  output logic                  busy,
  output logic                  done,
  spmv_rd_fetch_if.master       bus
);

  localparam int CW = LEN_WIDTH + 1;
  localparam int BW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_WIDTH-1:0]  BURST_MAX  = LEN_WIDTH'(BURST_LEN);
  localparam logic [CW-1:0]         CAPACITY   = CW'(2 ** FIFO_DEPTH);
  localparam logic [BW-1:0]         MAX_BURSTS = BW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  arvalid_q, arvalid_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [BW-1:0]         bursts_q, bursts_d;
  logic                  fetch_en_q, fetch_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  ar_hs_s;
  logic                  r_hs_s;
  logic [LEN_WIDTH-1:0]  size_s;
  logic [LEN_WIDTH-1:0]  hs_beats_s;
  logic [CW-1:0]         credit_sum_s;
  logic                  issue_ok_s;
  logic [CW-1:0]         out_inc_s;
  logic [BW-1:0]         bursts_inc_s;

  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = ~bus.fifo_full;
  assign bus.fifo_wr_en    = bus.m_axi_rvalid & ~bus.fifo_full;
  assign bus.fifo_data_in  = bus.m_axi_rdata;
  assign busy              = busy_q;
  assign done              = done_q;

  assign ar_hs_s    = arvalid_q & bus.m_axi_arready;
  assign r_hs_s     = bus.m_axi_rvalid & ~bus.fifo_full;
  assign size_s     = (remaining_q < BURST_MAX) ? remaining_q : BURST_MAX;
  assign hs_beats_s = LEN_WIDTH'(arlen_q) + LEN_WIDTH'(1);
  // Beats already in the FIFO plus beats still owed must leave room for the new burst.
  assign credit_sum_s = CW'(bus.fifo_fill_level) + outstanding_q + CW'(size_s);
  assign issue_ok_s   = fetch_en_q & (bursts_q < MAX_BURSTS) & (credit_sum_s <= CAPACITY)
                      & (remaining_q != {LEN_WIDTH{1'b0}});

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_beats == {LEN_WIDTH{1'b0}}) ? S_FINISH : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if ((remaining_q == {LEN_WIDTH{1'b0}}) && !arvalid_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (outstanding_q == {CW{1'b0}}) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request channel and command outputs
  always_comb begin
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arvalid_d   = arvalid_q;
    remaining_d = remaining_q;
    done_d      = (state_q == S_FINISH);
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          araddr_d    = base_addr;
          remaining_d = num_beats;
        end else begin
          araddr_d    = araddr_q;
        end
      end
      S_ISSUE: begin
        if (arvalid_q) begin
          if (bus.m_axi_arready) begin
            arvalid_d   = 1'b0;
            araddr_d    = araddr_q + ADDR_WIDTH'(hs_beats_s) * BEAT_BYTES;
            remaining_d = remaining_q - hs_beats_s;
          end else begin
            arvalid_d   = 1'b1;
          end
        end else if (issue_ok_s) begin
          arvalid_d = 1'b1;
          arlen_d   = 8'(size_s - LEN_WIDTH'(1));
        end else begin
          arvalid_d = 1'b0;
        end
      end
      default: arvalid_d = 1'b0;
    endcase
  end

  // Outstanding beat/burst credit and fetch hysteresis; decrements saturate at zero
  always_comb begin
    out_inc_s    = outstanding_q + (ar_hs_s ? CW'(hs_beats_s) : {CW{1'b0}});
    bursts_inc_s = bursts_q + (ar_hs_s ? BW'(1) : {BW{1'b0}});
    if (r_hs_s && (out_inc_s != {CW{1'b0}})) begin
      outstanding_d = out_inc_s - CW'(1);
    end else begin
      outstanding_d = out_inc_s;
    end
    if (r_hs_s && bus.m_axi_rlast && (bursts_inc_s != {BW{1'b0}})) begin
      bursts_d = bursts_inc_s - BW'(1);
    end else begin
      bursts_d = bursts_inc_s;
    end
    if (bus.fifo_noneeddata) begin
      fetch_en_d = 1'b0;
    end else if (bus.fifo_needdata) begin
      fetch_en_d = 1'b1;
    end else begin
      fetch_en_d = fetch_en_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      araddr_q      <= {ADDR_WIDTH{1'b0}};
      arlen_q       <= 8'd0;
      arvalid_q     <= 1'b0;
      remaining_q   <= {LEN_WIDTH{1'b0}};
      outstanding_q <= {CW{1'b0}};
      bursts_q      <= {BW{1'b0}};
      fetch_en_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      arvalid_q     <= arvalid_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      bursts_q      <= bursts_d;
      fetch_en_q    <= fetch_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_spmv_rd_fetch.sv
// Directed bench for spmv_rd_fetch: memory/FIFO model, expected-AR and
// expected-data scoreboards, and a monitor comparing at the falling edge.
module tb_spmv_rd_fetch;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int FD = 4;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_beats = '0;
  logic          busy, done;

  spmv_rd_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  spmv_rd_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(4), .FIFO_DEPTH(FD),
    .MAX_OUTSTANDING(4), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ar_count = 0;
  int wr_count = 0;
  int done_seen = 0;
  int done_exp  = 0;
  int fill = 0;
  bit drain_en = 1'b1;
  bit r_en = 1'b1;
  int ar_stall = 0;

  logic [AW-1:0] rq_addr[$];
  bit            rq_last[$];
  logic [AW-1:0] exp_ar_addr[$];
  logic [7:0]    exp_ar_len[$];
  logic [DW-1:0] exp_data[$];

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {8{a[31:0] ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic exp_bursts(input logic [AW-1:0] base, input int beats);
    int left = beats;
    logic [AW-1:0] a = base;
    while (left > 0) begin
      int sz = (left < 4) ? left : 4;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(8'(sz - 1));
      a = a + AW'(sz) * 64'd32;
      left = left - sz;
    end
    for (int i = 0; i < beats; i++) exp_data.push_back(data_of(base + AW'(i) * 64'd32));
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [LW-1:0] n);
    @(negedge clk);
    base_addr = a;
    num_beats = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && done_seen < done_exp; i++) @(negedge clk);
    chk_int({name, "_done"}, done_seen, done_exp);
    repeat (3) @(negedge clk);
    chk_int({name, "_ar_left"}, exp_ar_addr.size(), 0);
    chk_int({name, "_data_left"}, exp_data.size(), 0);
  endtask

  // Memory and FIFO model: drives at the falling edge, commits handshakes 1ns later
  initial begin
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata = '0;
    bus.m_axi_rlast = 1'b0;
    bus.fifo_full = 1'b0;
    bus.fifo_needdata = 1'b1;
    bus.fifo_noneeddata = 1'b0;
    bus.fifo_fill_level = '0;
    forever begin
      @(negedge clk);
      bus.m_axi_arready   = (ar_stall == 0);
      bus.m_axi_rvalid    = r_en && (rq_addr.size() > 0);
      bus.m_axi_rdata     = bus.m_axi_rvalid ? data_of(rq_addr[0]) : '0;
      bus.m_axi_rlast     = bus.m_axi_rvalid ? rq_last[0] : 1'b0;
      bus.fifo_fill_level = fill[FD:0];
      bus.fifo_full       = (fill >= 16);
      bus.fifo_needdata   = (fill < 4);
      bus.fifo_noneeddata = (fill > 12);
      #1;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        for (int k = 0; k <= int'(bus.m_axi_arlen); k++) begin
          rq_addr.push_back(bus.m_axi_araddr + AW'(k) * 64'd32);
          rq_last.push_back(k == int'(bus.m_axi_arlen));
        end
      end else if (bus.m_axi_arvalid && ar_stall > 0) begin
        ar_stall--;
      end
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        void'(rq_addr.pop_front());
        void'(rq_last.pop_front());
      end
      if (drain_en && fill > 0) fill--;
      if (bus.fifo_wr_en) fill++;
    end
  end

  // Monitor: compare AR requests, FIFO writes and done against the scoreboards
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rstn) begin
        if (bus.m_axi_arvalid) begin
          if (exp_ar_addr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ar_unexpected actual=%0h expected=no request", bus.m_axi_araddr);
          end else begin
            chk("ar_addr", DW'(bus.m_axi_araddr), DW'(exp_ar_addr[0]));
            chk("ar_len", DW'(bus.m_axi_arlen), DW'(exp_ar_len[0]));
            if (bus.m_axi_arready) begin
              void'(exp_ar_addr.pop_front());
              void'(exp_ar_len.pop_front());
              ar_count++;
            end
          end
        end
        if (bus.fifo_wr_en) begin
          wr_count++;
          if (exp_data.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL fifo_unexpected actual=%0h expected=no write", bus.fifo_data_in);
          end else begin
            chk("fifo_data", bus.fifo_data_in, exp_data.pop_front());
          end
        end
        if (bus.m_axi_rvalid) chk("no_overflow", DW'(bus.fifo_full), DW'(0));
        if (done) begin
          done_seen++;
          chk("busy_at_done", DW'(busy), DW'(0));
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int a0, w0;
    repeat (3) @(negedge clk);
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_arvalid", DW'(bus.m_axi_arvalid), DW'(0));
    chk("rst_araddr", DW'(bus.m_axi_araddr), DW'(0));
    chk("rst_arlen", DW'(bus.m_axi_arlen), DW'(0));
    rstn = 1'b1;

    // 16 beats: four full bursts
    a0 = ar_count; w0 = wr_count;
    exp_bursts(64'h1000, 16);
    done_exp++;
    do_start(64'h1000, 32'd16);
    chk("t1_busy", DW'(busy), DW'(1));
    chk("t1_arvalid_early", DW'(bus.m_axi_arvalid), DW'(0));
    @(negedge clk);
    chk("t1_first_ar", DW'(bus.m_axi_arvalid), DW'(1));
    wait_done("t1");
    chk_int("t1_ar_count", ar_count - a0, 4);
    chk_int("t1_wr_count", wr_count - w0, 16);

    // 10 beats: 4 + 4 + 2
    a0 = ar_count; w0 = wr_count;
    exp_bursts(64'h2000, 10);
    done_exp++;
    do_start(64'h2000, 32'd10);
    wait_done("t2");
    chk_int("t2_ar_count", ar_count - a0, 3);
    chk_int("t2_wr_count", wr_count - w0, 10);

    // zero beats: no request, done two cycles after start
    a0 = ar_count;
    done_exp++;
    do_start(64'h3000, 32'd0);
    chk("t3_busy", DW'(busy), DW'(1));
    chk("t3_done_early", DW'(done), DW'(0));
    @(negedge clk);
    chk("t3_busy_fall", DW'(busy), DW'(0));
    chk("t3_done", DW'(done), DW'(1));
    @(negedge clk);
    chk("t3_done_pulse", DW'(done), DW'(0));
    wait_done("t3");
    chk_int("t3_ar_count", ar_count - a0, 0);

    // FIFO not drained: credit stops requests at 16 beats, hysteresis restarts them
    a0 = ar_count; w0 = wr_count;
    drain_en = 1'b0;
    exp_bursts(64'h4000, 40);
    done_exp++;
    do_start(64'h4000, 32'd40);
    repeat (40) @(negedge clk);
    chk_int("t4_ar_stalled", ar_count - a0, 4);
    chk_int("t4_wr_stalled", wr_count - w0, 16);
    drain_en = 1'b1;
    for (int i = 0; i < 100 && fill >= 4; i++) @(negedge clk);
    chk_int("t4_hysteresis", ar_count - a0, 4);
    wait_done("t4");
    chk_int("t4_ar_count", ar_count - a0, 10);
    chk_int("t4_wr_count", wr_count - w0, 40);

    // arready held low for 5 cycles on the first burst
    a0 = ar_count; w0 = wr_count;
    ar_stall = 5;
    exp_bursts(64'h5000, 8);
    done_exp++;
    do_start(64'h5000, 32'd8);
    repeat (4) @(negedge clk);
    chk_int("t5_stall_ar", ar_count - a0, 0);
    chk_int("t5_stall_wr", wr_count - w0, 0);
    chk("t5_stall_valid", DW'(bus.m_axi_arvalid), DW'(1));
    wait_done("t5");
    chk_int("t5_ar_count", ar_count - a0, 2);

    // reset while draining with 3 beats owed, then a clean transfer
    a0 = ar_count;
    r_en = 1'b0;
    exp_bursts(64'h6000, 3);
    do_start(64'h6000, 32'd3);
    for (int i = 0; i < 50 && ar_count == a0; i++) @(negedge clk);
    chk_int("t6_ar_issued", ar_count - a0, 1);
    repeat (2) @(negedge clk);
    chk("t6_busy_drain", DW'(busy), DW'(1));
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", DW'(busy), DW'(0));
    chk("t6_rst_arvalid", DW'(bus.m_axi_arvalid), DW'(0));
    chk("t6_rst_done", DW'(done), DW'(0));
    rstn = 1'b1;
    rq_addr.delete();
    rq_last.delete();
    exp_data.delete();
    r_en = 1'b1;
    a0 = ar_count; w0 = wr_count;
    exp_bursts(64'h7000, 4);
    done_exp++;
    do_start(64'h7000, 32'd4);
    wait_done("t6");
    chk_int("t6_ar_count", ar_count - a0, 1);
    chk_int("t6_wr_count", wr_count - w0, 4);

    repeat (5) @(negedge clk);
    chk_int("done_total", done_seen, done_exp);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
